// File: rtl/bus_control_fsm.sv
// Microsequencer for the single-bus datapath: fetch, then per-class execute T-states.
// Strobes are decoded from the state register and ir. mdr_in also depends on mem_ready.
module bus_control_fsm (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic [4:0]  bus_sel,
    output logic        mar_in,
    output logic        mdr_in,
    output logic        ir_in,
    output logic        y_in,
    output logic        z_in,
    output logic        pc_in,
    output logic        hi_in,
    output logic        lo_in,
    output logic        rf_in,
    output logic [3:0]  rf_wsel,
    output logic        inc_pc,
    output logic        mem_read,
    output logic [4:0]  alu_op,
    output logic        instr_done,
    output logic        halted
);

    // state  | meaning
    // IDLE   | waiting for run
    // T0     | PC -> MAR, Z = PC + 1
    // T1     | Z -> PC (first cycle), wait for memory, MDR load
    // T2     | MDR -> IR
    // T3..T6 | per-class execute steps
    // HALT   | absorbing, left only through clear
    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_HALT = 4'd8;

    localparam logic [2:0] C_ALUR   = 3'd0;
    localparam logic [2:0] C_ALUI   = 3'd1;
    localparam logic [2:0] C_MULDIV = 3'd2;
    localparam logic [2:0] C_MFHL   = 3'd3;
    localparam logic [2:0] C_NOP    = 3'd4;
    localparam logic [2:0] C_HALT   = 3'd5;

    localparam logic [4:0] OP_MFHI = 5'd24;
    localparam logic [4:0] OP_HALT = 5'd27;

    localparam logic [4:0] SEL_HI   = 5'd16;
    localparam logic [4:0] SEL_LO   = 5'd17;
    localparam logic [4:0] SEL_ZHI  = 5'd18;
    localparam logic [4:0] SEL_ZLO  = 5'd19;
    localparam logic [4:0] SEL_PC   = 5'd20;
    localparam logic [4:0] SEL_MDR  = 5'd21;
    localparam logic [4:0] SEL_SEXT = 5'd23;
    localparam logic [4:0] SEL_NONE = 5'd31;

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic       pc_loaded;
    logic [2:0] cls;
    logic [4:0] alu_code;
    logic       final_step;

    logic [4:0] opcode;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       unused_ir;

    assign opcode    = ir[31:27];
    assign ra        = ir[26:23];
    assign rb        = ir[22:19];
    assign rc        = ir[18:15];
    assign unused_ir = ^ir[14:0];

    always_comb begin
        cls      = C_NOP;
        alu_code = 5'd0;
        case (opcode) inside
            [5'd0:5'd8]: begin
                cls      = C_ALUR;
                alu_code = opcode;
            end
            5'd9: begin
                cls      = C_ALUI;
                alu_code = 5'd0;
            end
            5'd10: begin
                cls      = C_ALUI;
                alu_code = 5'd2;
            end
            5'd11: begin
                cls      = C_ALUI;
                alu_code = 5'd3;
            end
            5'd15, 5'd16: begin
                cls      = C_MULDIV;
                alu_code = opcode;
            end
            5'd24, 5'd25: cls = C_MFHL;
            OP_HALT:      cls = C_HALT;
            default:      cls = C_NOP;
        endcase
    end

    always_comb begin
        final_step = 1'b0;
        case (state)
            S_T3:    final_step = (cls == C_MFHL) || (cls == C_NOP) || (cls == C_HALT);
            S_T5:    final_step = (cls == C_ALUR) || (cls == C_ALUI);
            S_T6:    final_step = 1'b1;
            default: final_step = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: state_nxt = run ? S_T0 : S_IDLE;
            S_T0:   state_nxt = S_T1;
            S_T1:   state_nxt = mem_ready ? S_T2 : S_T1;
            S_T2:   state_nxt = S_T3;
            S_T3: begin
                if (cls == C_HALT)
                    state_nxt = S_HALT;
                else if (final_step)
                    state_nxt = run ? S_T0 : S_IDLE;
                else
                    state_nxt = S_T4;
            end
            S_T4:   state_nxt = S_T5;
            S_T5:   state_nxt = final_step ? (run ? S_T0 : S_IDLE) : S_T6;
            S_T6:   state_nxt = run ? S_T0 : S_IDLE;
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state     <= S_IDLE;
            pc_loaded <= 1'b0;
        end else begin
            state     <= state_nxt;
            // remembers that PC was already loaded during T1 wait states
            pc_loaded <= (state == S_T1);
        end
    end

    always_comb begin
        bus_sel  = SEL_NONE;
        mar_in   = 1'b0;
        mdr_in   = 1'b0;
        ir_in    = 1'b0;
        y_in     = 1'b0;
        z_in     = 1'b0;
        pc_in    = 1'b0;
        hi_in    = 1'b0;
        lo_in    = 1'b0;
        rf_in    = 1'b0;
        rf_wsel  = 4'd0;
        inc_pc   = 1'b0;
        mem_read = 1'b0;
        alu_op   = 5'd0;
        case (state)
            S_T0: begin
                bus_sel = SEL_PC;
                mar_in  = 1'b1;
                inc_pc  = 1'b1;
                z_in    = 1'b1;
            end
            S_T1: begin
                bus_sel  = SEL_ZLO;
                mem_read = 1'b1;
                pc_in    = !pc_loaded;
                mdr_in   = mem_ready;
            end
            S_T2: begin
                bus_sel = SEL_MDR;
                ir_in   = 1'b1;
            end
            S_T3: begin
                case (cls)
                    C_ALUR, C_ALUI: begin
                        bus_sel = {1'b0, rb};
                        y_in    = 1'b1;
                    end
                    C_MULDIV: begin
                        bus_sel = {1'b0, ra};
                        y_in    = 1'b1;
                    end
                    C_MFHL: begin
                        bus_sel = (opcode == OP_MFHI) ? SEL_HI : SEL_LO;
                        rf_in   = 1'b1;
                        rf_wsel = ra;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    C_ALUR: begin
                        bus_sel = {1'b0, rc};
                        z_in    = 1'b1;
                        alu_op  = alu_code;
                    end
                    C_ALUI: begin
                        bus_sel = SEL_SEXT;
                        z_in    = 1'b1;
                        alu_op  = alu_code;
                    end
                    C_MULDIV: begin
                        bus_sel = {1'b0, rb};
                        z_in    = 1'b1;
                        alu_op  = alu_code;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    C_ALUR, C_ALUI: begin
                        bus_sel = SEL_ZLO;
                        rf_in   = 1'b1;
                        rf_wsel = ra;
                    end
                    C_MULDIV: begin
                        bus_sel = SEL_ZLO;
                        lo_in   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                if (cls == C_MULDIV) begin
                    bus_sel = SEL_ZHI;
                    hi_in   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign instr_done = final_step;
    assign halted     = (state == S_HALT);

endmodule

// File: tb/tb_bus_control_fsm.sv
// Scoreboard bench for bus_control_fsm: per-cycle expected strobe vectors are queued as
// stimulus is driven and compared against the outputs on the falling edge.
module tb_bus_control_fsm;

    typedef struct packed {
        logic [4:0] bus_sel;
        logic       mar_in;
        logic       mdr_in;
        logic       ir_in;
        logic       y_in;
        logic       z_in;
        logic       pc_in;
        logic       hi_in;
        logic       lo_in;
        logic       rf_in;
        logic [3:0] rf_wsel;
        logic       inc_pc;
        logic       mem_read;
        logic [4:0] alu_op;
        logic       instr_done;
        logic       halted;
    } ov_t;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        run = 1'b0;
    logic [31:0] ir = 32'd0;
    logic        mem_ready = 1'b0;
    logic [4:0]  bus_sel;
    logic        mar_in, mdr_in, ir_in, y_in, z_in, pc_in, hi_in, lo_in, rf_in;
    logic [3:0]  rf_wsel;
    logic        inc_pc, mem_read;
    logic [4:0]  alu_op;
    logic        instr_done, halted;

    ov_t   obs;
    ov_t   exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    bus_control_fsm dut (
        .clock      (clock),
        .clear      (clear),
        .run        (run),
        .ir         (ir),
        .mem_ready  (mem_ready),
        .bus_sel    (bus_sel),
        .mar_in     (mar_in),
        .mdr_in     (mdr_in),
        .ir_in      (ir_in),
        .y_in       (y_in),
        .z_in       (z_in),
        .pc_in      (pc_in),
        .hi_in      (hi_in),
        .lo_in      (lo_in),
        .rf_in      (rf_in),
        .rf_wsel    (rf_wsel),
        .inc_pc     (inc_pc),
        .mem_read   (mem_read),
        .alu_op     (alu_op),
        .instr_done (instr_done),
        .halted     (halted)
    );

    always #5 clock = ~clock;

    assign obs = {bus_sel, mar_in, mdr_in, ir_in, y_in, z_in, pc_in, hi_in, lo_in,
                  rf_in, rf_wsel, inc_pc, mem_read, alu_op, instr_done, halted};

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            ov_t   e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk_eq(t, 32'(obs), 32'(e));
        end
    end

    function automatic ov_t nul();
        ov_t v;
        v = '0;
        v.bus_sel = 5'd31;
        return v;
    endfunction

    function automatic logic [31:0] mk_ir(input int op, input int ra, input int rb, input int rc);
        return {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'($urandom_range(0, 32767))};
    endfunction

    // queue the expectation for the state the DUT is in now, then advance one cycle
    task automatic cyc(input ov_t e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input int waits);
        ov_t e;
        mem_ready = 1'($urandom_range(0, 1));
        e = nul();
        e.bus_sel = 5'd20;
        e.mar_in  = 1'b1;
        e.inc_pc  = 1'b1;
        e.z_in    = 1'b1;
        cyc(e, "t0");
        for (int w = 0; w <= waits; w++) begin
            mem_ready = (w == waits);
            e = nul();
            e.bus_sel  = 5'd19;
            e.mem_read = 1'b1;
            e.pc_in    = (w == 0);
            e.mdr_in   = (w == waits);
            cyc(e, "t1");
        end
        mem_ready = 1'($urandom_range(0, 1));
        e = nul();
        e.bus_sel = 5'd21;
        e.ir_in   = 1'b1;
        cyc(e, "t2");
    endtask

    task automatic exec_instr(input logic run_next);
        ov_t        e;
        int         op;
        logic [3:0] ra, rb, rc;
        logic [4:0] aop;
        op = int'(ir[31:27]);
        ra = ir[26:23];
        rb = ir[22:19];
        rc = ir[18:15];
        mem_ready = 1'($urandom_range(0, 1));
        if (op <= 11) begin
            aop = (op <= 8) ? 5'(op) : (op == 9) ? 5'd0 : (op == 10) ? 5'd2 : 5'd3;
            e = nul(); e.bus_sel = {1'b0, rb}; e.y_in = 1'b1;
            cyc(e, "alu_t3");
            e = nul(); e.bus_sel = (op <= 8) ? {1'b0, rc} : 5'd23; e.z_in = 1'b1; e.alu_op = aop;
            cyc(e, "alu_t4");
            run = run_next;
            e = nul(); e.bus_sel = 5'd19; e.rf_in = 1'b1; e.rf_wsel = ra; e.instr_done = 1'b1;
            cyc(e, "alu_t5");
        end else if (op == 15 || op == 16) begin
            e = nul(); e.bus_sel = {1'b0, ra}; e.y_in = 1'b1;
            cyc(e, "md_t3");
            e = nul(); e.bus_sel = {1'b0, rb}; e.z_in = 1'b1; e.alu_op = 5'(op);
            cyc(e, "md_t4");
            e = nul(); e.bus_sel = 5'd19; e.lo_in = 1'b1;
            cyc(e, "md_t5");
            run = run_next;
            e = nul(); e.bus_sel = 5'd18; e.hi_in = 1'b1; e.instr_done = 1'b1;
            cyc(e, "md_t6");
        end else if (op == 24 || op == 25) begin
            run = run_next;
            e = nul(); e.bus_sel = (op == 24) ? 5'd16 : 5'd17; e.rf_in = 1'b1; e.rf_wsel = ra;
            e.instr_done = 1'b1;
            cyc(e, "mf_t3");
        end else begin
            run = run_next;
            e = nul(); e.instr_done = 1'b1;
            cyc(e, "nop_t3");
        end
    endtask

    task automatic do_instr(input logic [31:0] iv, input int waits, input logic run_next);
        ir = iv;
        fetch(waits);
        exec_instr(run_next);
    endtask

    initial begin
        ov_t e;
        int  ops[10] = '{1, 10, 11, 16, 24, 26, 13, 31, 25, 8};

        #2;
        chk_eq("reset_vec", 32'(obs), 32'(nul()));
        #6 clear = 1'b1;
        @(posedge clock); #1;
        for (int i = 0; i < 3; i++) cyc(nul(), "idle_run0");

        run = 1'b1;
        ir  = mk_ir(0, 1, 2, 3);
        cyc(nul(), "idle_go");
        do_instr(mk_ir(0, 1, 2, 3), 0, 1'b1);
        do_instr(mk_ir(0, 1, 2, 3), 3, 1'b1);
        do_instr(mk_ir(15, 4, 5, 0), 0, 1'b1);
        do_instr(mk_ir(9, 6, 2, 0), 0, 1'b1);
        do_instr(mk_ir(25, 7, 0, 0), 0, 1'b1);
        for (int i = 0; i < 10; i++)
            do_instr(mk_ir(ops[i], $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15)),
                     $urandom_range(0, 2), (i != 9));
        for (int i = 0; i < 3; i++) cyc(nul(), "idle_after");

        // clear during T4 of ADD drops the strobes asynchronously
        run = 1'b1;
        ir  = mk_ir(0, 1, 2, 3);
        cyc(nul(), "idle_go2");
        fetch(0);
        e = nul(); e.bus_sel = 5'd2; e.y_in = 1'b1;
        cyc(e, "add_t3");
        #1;
        e = nul(); e.bus_sel = 5'd3; e.z_in = 1'b1;
        chk_eq("add_t4_live", 32'(obs), 32'(e));
        clear = 1'b0;
        #1;
        chk_eq("add_t4_clear", 32'(obs), 32'(nul()));
        @(negedge clock);
        clear = 1'b1;
        run   = 1'b0;
        @(posedge clock); #1;
        for (int i = 0; i < 3; i++) cyc(nul(), "idle_post_clr");

        run = 1'b1;
        ir  = mk_ir(27, 0, 0, 0);
        cyc(nul(), "idle_go3");
        fetch(1);
        chk_eq("halt_t3_bus", 32'(bus_sel), 32'd31);
        chk_eq("halt_t3_flag", 32'(halted), 32'd0);
        @(posedge clock); #1;
        for (int i = 0; i < 8; i++) begin
            run       = 1'($urandom_range(0, 1));
            mem_ready = 1'($urandom_range(0, 1));
            e = nul(); e.halted = 1'b1;
            cyc(e, "halt_hold");
        end
        clear = 1'b0;
        #1;
        chk_eq("halt_clear", 32'(obs), 32'(nul()));
        @(negedge clock);
        clear = 1'b1;
        run   = 1'b0;
        @(posedge clock); #1;
        for (int i = 0; i < 2; i++) cyc(nul(), "idle_end");
        @(negedge clock); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
